// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared defaults and sizing helpers for the fetch buffer stage.
// Revision : 1.0 - initial release
// ============================================================================

package fetch_pkg;

  localparam int          WORD_LEN_DEFAULT = 32;
  localparam int          PC_STEP_DEFAULT  = 4;
  localparam int unsigned RESET_PC_DEFAULT = 32'h0000_0000;

  // Occupancy counters need one extra bit so that "full" (== DEPTH) is representable.
  function automatic int levelWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_buffer_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer_stage_if
// Brief    : Branch, instruction-memory and decode handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================

interface fetch_buffer_stage_if
  import fetch_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEFAULT,
  parameter int DEPTH    = 4
);

  localparam int LEVEL_W = levelWidth(DEPTH);

  logic                br_taken;
  logic [WORD_LEN-1:0] br_base;
  logic [WORD_LEN-1:0] br_offset;

  logic                imem_req;
  logic [WORD_LEN-1:0] imem_addr;
  logic [WORD_LEN-1:0] imem_rdata;

  logic                out_valid;
  logic                out_ready;
  logic [WORD_LEN-1:0] out_pc;
  logic [WORD_LEN-1:0] out_instr;
  logic [LEVEL_W-1:0]  level;

  // master is the fetch stage itself; slave is the execute/imem/decode side.
  modport master (
    input  br_taken, br_base, br_offset, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_instr, level
  );

  modport slave (
    output br_taken, br_base, br_offset, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_instr, level
  );

endinterface : fetch_buffer_stage_if

`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO with single-cycle flush for the prefetch queue.
// Revision : 1.0 - initial release
// ============================================================================

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_pushData,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_popData,
  output logic [levelWidth(DEPTH)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = levelWidth(DEPTH);

  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_doPush;
  logic w_doPop;

  assign w_full   = (r_count == C_FULL);
  assign w_empty  = (r_count == '0);
  // Guard against overflow/underflow even though the owner never asks for it.
  assign w_doPush = i_push && !w_full && !i_flush;
  assign w_doPop  = i_pop && !w_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_popData = r_mem[r_rdPtr];
  assign o_count   = r_count;

endmodule : fetch_fifo

`default_nettype wire

// File: rtl/fetch_buffer_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer_stage
// Brief    : Instruction fetch with one-deep in-flight tracking and prefetch queue.
// Revision : 1.0 - initial release
// ============================================================================

module fetch_buffer_stage
  import fetch_pkg::*;
#(
  parameter int                  WORD_LEN = WORD_LEN_DEFAULT,
  parameter int                  DEPTH    = 4,
  parameter logic [WORD_LEN-1:0] RESET_PC = WORD_LEN'(RESET_PC_DEFAULT),
  parameter int                  PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_buffer_stage_if.master fbBus
);

  localparam int LEVEL_W = levelWidth(DEPTH);
  localparam int ENTRY_W = 2 * WORD_LEN;

  localparam logic [WORD_LEN-1:0] C_PC_STEP = WORD_LEN'(PC_STEP);
  localparam logic [LEVEL_W:0]    C_DEPTH   = (LEVEL_W + 1)'(DEPTH);

  logic [WORD_LEN-1:0] r_fetchPc;
  logic [WORD_LEN-1:0] r_issuedPc;
  logic                r_inflight;

  logic [LEVEL_W-1:0]  w_count;
  logic [LEVEL_W:0]    w_budgetUsed;
  logic [ENTRY_W-1:0]  w_pushEntry;
  logic [ENTRY_W-1:0]  w_headEntry;
  logic [WORD_LEN-1:0] w_brTarget;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_outValid;

  // An outstanding read already owns a slot; a pop this cycle does not free one.
  assign w_budgetUsed = {1'b0, w_count} + (LEVEL_W + 1)'(r_inflight);
  assign w_issue      = !rst && !fbBus.br_taken && (w_budgetUsed < C_DEPTH);

  assign w_push      = !rst && !fbBus.br_taken && r_inflight;
  assign w_pushEntry = {r_issuedPc, fbBus.imem_rdata};

  assign w_outValid = !rst && !fbBus.br_taken && (w_count != '0);
  assign w_pop      = w_outValid && fbBus.out_ready;

  assign w_brTarget = fbBus.br_base + {fbBus.br_offset[WORD_LEN-3:0], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchPc  <= RESET_PC;
      r_issuedPc <= RESET_PC;
      r_inflight <= 1'b0;
    end else if (fbBus.br_taken) begin
      // The word returning this cycle belongs to the wrong path and is dropped.
      r_fetchPc  <= w_brTarget;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetchPc  <= r_fetchPc + C_PC_STEP;
        r_issuedPc <= r_fetchPc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (fbBus.br_taken),
    .i_push     (w_push),
    .i_pushData (w_pushEntry),
    .i_pop      (w_pop),
    .o_popData  (w_headEntry),
    .o_count    (w_count)
  );

  assign fbBus.imem_req  = w_issue;
  assign fbBus.imem_addr = r_fetchPc;
  assign fbBus.out_valid = w_outValid;
  assign fbBus.out_pc    = w_headEntry[ENTRY_W-1:WORD_LEN];
  assign fbBus.out_instr = w_headEntry[WORD_LEN-1:0];
  assign fbBus.level     = rst ? '0 : w_count;

endmodule : fetch_buffer_stage

`default_nettype wire

// File: tb/tb_fetch_buffer_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_buffer_stage
// Brief    : Directed + scoreboard bench for fetch_buffer_stage (DEPTH=4, 32-bit).
// Revision : 1.0 - initial release
// ============================================================================

module tb_fetch_buffer_stage;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] C_STEP = 32'd4;
  localparam logic [31:0] C_RPC  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic clk;
  logic rst;

  fetch_buffer_stage_if #(.WORD_LEN(32), .DEPTH(DEPTH)) bus ();

  fetch_buffer_stage #(
    .WORD_LEN (32),
    .DEPTH    (DEPTH),
    .RESET_PC (C_RPC),
    .PC_STEP  (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .fbBus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: word at byte address A is A/4, valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= bus.imem_addr >> 2;
    else              bus.imem_rdata <= $urandom();
  end

  int nAsserts = 0;
  int nFail    = 0;

  // Reference model state; mQ is the scoreboard of expected decode outputs.
  logic [31:0] mPc       = C_RPC;
  logic [31:0] mCapPc    = C_RPC;
  logic        mInflight = 1'b0;
  entry_t      mQ[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelCycle();
    logic expReq;
    logic expValid;
    int   occ;
    occ      = mQ.size() + (mInflight ? 1 : 0);
    expReq   = !rst && !bus.br_taken && (occ < DEPTH);
    expValid = !rst && !bus.br_taken && (mQ.size() != 0);
    chk("imem_req", 32'(bus.imem_req), 32'(expReq));
    if (expReq) chk("imem_addr", bus.imem_addr, mPc);
    chk("out_valid", 32'(bus.out_valid), 32'(expValid));
    if (expValid) begin
      chk("out_pc", bus.out_pc, mQ[0].pc);
      chk("out_instr", bus.out_instr, mQ[0].instr);
    end
    chk("level", 32'(bus.level), rst ? 32'd0 : 32'(mQ.size()));
    if (rst) begin
      mPc       = C_RPC;
      mInflight = 1'b0;
      mQ.delete();
    end else if (bus.br_taken) begin
      mPc       = bus.br_base + (bus.br_offset << 2);
      mInflight = 1'b0;
      mQ.delete();
    end else begin
      if (expValid && bus.out_ready) void'(mQ.pop_front());
      if (mInflight) mQ.push_back('{pc: mCapPc, instr: mCapPc >> 2});
      if (expReq) begin
        mCapPc    = mPc;
        mPc       = mPc + C_STEP;
        mInflight = 1'b1;
      end else begin
        mInflight = 1'b0;
      end
    end
  endtask

  task automatic mid();
    @(negedge clk);
    modelCycle();
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      mid();
      fin();
    end
  endtask

  task automatic setBr(input logic t, input logic [31:0] base, input logic [31:0] off);
    bus.br_taken  = t;
    bus.br_base   = base;
    bus.br_offset = off;
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    setBr(1'b0, 32'h0, 32'h0);

    // Reset state
    mid();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    fin();
    run(2);

    // Streaming from release: requests 0,4,8; first output two cycles later
    rst = 1'b0;
    mid(); chk("s_addr0", bus.imem_addr, 32'h0); chk("s_req0", 32'(bus.imem_req), 32'd1);
    chk("s_val0", 32'(bus.out_valid), 32'd0); fin();
    mid(); chk("s_addr1", bus.imem_addr, 32'h4); chk("s_val1", 32'(bus.out_valid), 32'd0); fin();
    mid(); chk("s_val2", 32'(bus.out_valid), 32'd1); chk("s_pc2", bus.out_pc, 32'h0);
    chk("s_instr2", bus.out_instr, 32'h0); fin();
    mid(); chk("s_pc3", bus.out_pc, 32'h4); chk("s_instr3", bus.out_instr, 32'h1); fin();
    run(4);

    // Back-pressure from release: exactly four requests, then stall at level 4
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("bp_req", 32'(bus.imem_req), 32'd1);
      chk("bp_addr", bus.imem_addr, 32'(4 * i));
      fin();
    end
    mid(); chk("bp_stop", 32'(bus.imem_req), 32'd0); fin();
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("bp_level", 32'(bus.level), 32'd4);
      chk("bp_idle", 32'(bus.imem_req), 32'd0);
      fin();
    end
    bus.out_ready = 1'b1;
    mid(); chk("dr_pc0", bus.out_pc, 32'h0); chk("dr_req0", 32'(bus.imem_req), 32'd0); fin();
    mid(); chk("dr_pc1", bus.out_pc, 32'h4); chk("dr_addr1", bus.imem_addr, 32'h10);
    chk("dr_req1", 32'(bus.imem_req), 32'd1); fin();
    mid(); chk("dr_pc2", bus.out_pc, 32'h8); fin();
    mid(); chk("dr_pc3", bus.out_pc, 32'hC); fin();
    run(4);

    // Redirect in steady stream: target 0x40 + (-4 << 2) = 0x30
    setBr(1'b1, 32'h40, 32'hFFFF_FFFC);
    mid(); chk("br_valid", 32'(bus.out_valid), 32'd0); chk("br_req", 32'(bus.imem_req), 32'd0); fin();
    setBr(1'b0, 32'h0, 32'h0);
    mid(); chk("br_level", 32'(bus.level), 32'd0); chk("br_addr", bus.imem_addr, 32'h30);
    chk("br_req1", 32'(bus.imem_req), 32'd1); fin();
    mid(); fin();
    mid(); chk("br_first_pc", bus.out_pc, 32'h30); chk("br_first_instr", bus.out_instr, 32'hC); fin();
    run(3);

    // Redirect held three cycles with changing targets
    setBr(1'b1, 32'h100, 32'h0);
    mid(); chk("hold_req0", 32'(bus.imem_req), 32'd0); fin();
    setBr(1'b1, 32'h200, 32'h4);
    mid(); chk("hold_req1", 32'(bus.imem_req), 32'd0); fin();
    setBr(1'b1, 32'h1000, 32'h8);
    mid(); chk("hold_req2", 32'(bus.imem_req), 32'd0); chk("hold_val2", 32'(bus.out_valid), 32'd0); fin();
    setBr(1'b0, 32'h0, 32'h0);
    mid(); chk("hold_addr", bus.imem_addr, 32'h1020); chk("hold_req3", 32'(bus.imem_req), 32'd1); fin();
    run(3);

    // Randomised back-pressure and occasional redirects
    for (int i = 0; i < 40; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0)
        setBr(1'b1, 32'($urandom_range(0, 1023)) << 2, 32'($urandom_range(0, 15)) - 32'd8);
      else
        setBr(1'b0, 32'h0, 32'h0);
      run(1);
    end
    setBr(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    run(3);

    // PC wrap-around at the top of the address space
    setBr(1'b1, 32'hFFFF_FFF8, 32'h1);
    run(1);
    setBr(1'b0, 32'h0, 32'h0);
    mid(); chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC); fin();
    mid(); chk("wrap_addr1", bus.imem_addr, 32'h0000_0000); fin();
    run(4);

    // Reset mid-operation with three queued entries
    bus.out_ready = 1'b0;
    setBr(1'b1, 32'h80, 32'h0);
    run(1);
    setBr(1'b0, 32'h0, 32'h0);
    run(4);
    mid(); chk("mr_level3", 32'(bus.level), 32'd3); fin();
    rst = 1'b1;
    mid(); chk("mr_rst_level", 32'(bus.level), 32'd0); chk("mr_rst_req", 32'(bus.imem_req), 32'd0);
    chk("mr_rst_valid", 32'(bus.out_valid), 32'd0); fin();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    mid(); chk("mr_addr", bus.imem_addr, C_RPC); chk("mr_req", 32'(bus.imem_req), 32'd1);
    chk("mr_level0", 32'(bus.level), 32'd0); fin();
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule : tb_fetch_buffer_stage

`default_nettype wire
